uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmitter between NUM_REQ byte requesters. It sits between the requesters and the transmitter's tx_start/DATA/tx_done handshake, so the transmitter itself is unchanged. The block issues one frame at a time and can hold the grant for a multi-byte packet. A watchdog recovers the scheduler if tx_done never arrives.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 100000: clock cycles allowed in WAIT before abort; at least 1.
- GAP_CYCLES, 0: idle clock cycles inserted after each frame; 0 means no gap.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte available; held until req_ready.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the last of its packet.
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- tx_start  out  1  one-cycle pulse to the transmitter's tx_start.
- tx_data  out  8  byte to the transmitter's DATA; stable from START until the next START.
- tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- grant  out  NUM_REQ  one-hot current owner; high from START through WAIT.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse when the watchdog fires.
- err_id  out  clog2(NUM_REQ)  owner at the last timeout; holds its value until the next timeout.

## Operation
- States: IDLE, START, WAIT, GAP.
- **IDLE**
  - If the lock is clear, eligible = req_valid. If the lock is set, eligible = req_valid of the lock owner only.
  - If any requester is eligible, select g = the first eligible index at or after rr_ptr, searching upward mod NUM_REQ.
  - Register g, latch req_data[g] into tx_data and latch req_last[g], then go to START.
- **START** (exactly 1 cycle)
  - tx_start=1, req_ready[g]=1, grant[g]=1.
  - rr_ptr ← (g+1) mod NUM_REQ.
  - Lock: if req_last[g]=0, set lock with owner g; otherwise clear lock.
  - Clear the watchdog counter and go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - If tx_done=1: go to GAP, or to IDLE when GAP_CYCLES=0.
  - Else if counter = TIMEOUT_CYCLES-1: err_timeout=1, err_id←g, clear lock, then go to GAP or IDLE as above.
  - If tx_done and the timeout occur in the same cycle, tx_done wins and no error is flagged.
- **GAP**: count GAP_CYCLES cycles, then go to IDLE. tx_done is ignored here.
- Lock behaviour:
  - Non-owners are starved until the owner sends a byte with last=1 or a timeout occurs.
  - If the locked owner drops req_valid, the scheduler waits in IDLE and the lock stays set.
- Widths:
  - rr_ptr and err_id are clog2(NUM_REQ) bits.
  - The watchdog counter is clog2(TIMEOUT_CYCLES+1) bits.
  - rr_ptr wraps from NUM_REQ-1 to 0.

## Timing
- Reset values: state=IDLE, rr_ptr=0, lock clear, counters 0. All outputs are 0: req_ready, tx_start, tx_data=8'h00, grant, busy, err_timeout, err_id.
- Reset asserted in any state returns the block to reset values immediately. Any frame in flight is abandoned and no req_ready is issued for it.
- Latency:
  - req_valid sampled high in IDLE at cycle t gives tx_start and req_ready at t+1.
  - Next possible START after tx_done at cycle d: d+2+GAP_CYCLES.
- Requester rules:
  - req_data and req_last must be stable while req_valid is high.
  - The requester may change data, or drop valid, in the cycle after req_ready.
  - A request withdrawn before it is selected is legal.
- tx_start and req_ready are never high for more than one cycle and are never high outside START.
- tx_done arriving in IDLE, START or GAP has no effect.

## Test plan
- **Single byte.** Requester 1 sends 8'hA5 with last=1.
  - One cycle later: tx_start=1, req_ready=4'b0010, tx_data=A5.
  - After tx_done, busy falls on the next cycle (GAP_CYCLES=0).
- **Fairness.** All four requesters are held valid with last=1.
  - Grant order is 0,1,2,3,0,1.
  - Each grant receives exactly one req_ready.
- **Packet lock.** Requester 2 sends 3 bytes (last=0,0,1) while requester 0 is continuously valid.
  - Order is 2,2,2, then 0.
  - Requester 0 gets no req_ready during the packet.
- **Timeout.** TIMEOUT_CYCLES=20; requester 3 is granted and tx_done is never pulsed.
  - err_timeout pulses exactly 20 cycles after START, with err_id=3.
  - The lock is released and the next grant can go to another requester.
- **Tie in WAIT.** tx_done arrives in the same cycle the counter reaches TIMEOUT_CYCLES-1.
  - No err_timeout; the scheduler proceeds normally.
- **Reset mid-frame.** Assert reset during WAIT with grant=4'b0100, then release.
  - All outputs read 0 immediately.
  - After release, the first grant goes to the lowest-index valid requester, since rr_ptr is back at 0.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the byte requesters, the scheduler and the UART transmitter.
// master drives requests and tx_done; slave is the scheduler.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 err_timeout;
    logic [IW-1:0]        err_id;

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_start, tx_data, grant,
        input  busy, err_timeout, err_id
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_start, tx_data, grant,
        output busy, err_timeout, err_id
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources,
// with packet lock and a tx_done watchdog.
module uart_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int GAP_CYCLES     = 0
) (
    input logic                clock,
    input logic                reset,
    uart_tx_scheduler_if.slave bus
);
    localparam int IW    = $clog2(NUM_REQ);
    localparam int CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GLAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GEND  = GW'(GLAST);
    localparam logic [IW-1:0] PMAX  = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    localparam state_t S_AFTER = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    state_t r_state;
    state_t w_next;

    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_gnt;
    logic [7:0]         r_txd;
    logic               r_last;
    logic               r_lock;
    logic [CW-1:0]      r_wd;
    logic [GW-1:0]      r_gap;
    logic [IW-1:0]      r_err_id;

    logic [NUM_REQ-1:0] w_onehot;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_found;
    logic [IW-1:0]      w_sel;
    logic [7:0]         w_sel_data;
    logic               w_sel_last;
    int                 w_idx;

    logic [NUM_REQ-1:0] w_ready;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_tx_start;
    logic               w_errt;

    assign w_onehot = NUM_REQ'(1) << r_gnt;
    // While locked, r_gnt still names the packet owner.
    assign w_elig = r_lock ? (bus.req_valid & w_onehot)
                           : bus.req_valid;

    // Scan downward so the closest index at/after r_ptr wins.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_sel_data = 8'h00;
        w_sel_last = 1'b0;
        w_idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (w_elig[w_idx]) begin
                w_found    = 1'b1;
                w_sel      = IW'(w_idx);
                w_sel_data = bus.req_data[w_idx*8 +: 8];
                w_sel_last = bus.req_last[w_idx];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_tx_start = 1'b0;
        w_ready    = '0;
        w_grant    = '0;
        w_errt     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_START;
            end
            S_START: begin
                w_tx_start = 1'b1;
                w_ready    = w_onehot;
                w_grant    = w_onehot;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                w_grant = w_onehot;
                if (bus.tx_done) begin
                    w_next = S_AFTER;
                end else if (r_wd == TLAST) begin
                    w_errt = 1'b1;
                    w_next = S_AFTER;
                end
            end
            S_GAP: begin
                if (r_gap == GEND) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_txd    <= 8'h00;
            r_last   <= 1'b0;
            r_lock   <= 1'b0;
            r_wd     <= '0;
            r_gap    <= '0;
            r_err_id <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt  <= w_sel;
                        r_txd  <= w_sel_data;
                        r_last <= w_sel_last;
                    end
                end
                S_START: begin
                    r_ptr  <= (r_gnt == PMAX) ? '0 : r_gnt + IW'(1);
                    r_lock <= ~r_last;
                    r_wd   <= '0;
                end
                S_WAIT: begin
                    r_wd  <= r_wd + CW'(1);
                    r_gap <= '0;
                    if (w_errt) begin
                        r_err_id <= r_gnt;
                        r_lock   <= 1'b0;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + GW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.tx_start    = w_tx_start;
    assign bus.tx_data     = r_txd;
    assign bus.grant       = w_grant;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.err_timeout = w_errt;
    assign bus.err_id      = r_err_id;
endmodule
